// File: rtl/key_array_if.sv
// Handshake and data bundle between the AES key port, the round-key logic
// and the key_array_seq key store.
interface key_array_if #(
    parameter int W   = 16,
    parameter int RIW = 4
) ();
    logic           load_start;
    logic           round_start;
    logic           rot_start;
    logic [W-1:0]   key_in;
    logic           key_valid;
    logic           key_ready;
    logic [W-1:0]   RK;
    logic [W-1:0]   key_out;
    logic           key_out_valid;
    logic [W-1:0]   to_sbox;
    logic [W-1:0]   to_kronecker;
    logic           busy;
    logic           done;
    logic [RIW-1:0] round_idx;
    logic           cmd_err;

    modport master (
        output load_start, round_start, rot_start,
        output key_in, key_valid, RK,
        input  key_ready, key_out, key_out_valid,
        input  to_sbox, to_kronecker,
        input  busy, done, round_idx, cmd_err
    );

    modport slave (
        input  load_start, round_start, rot_start,
        input  key_in, key_valid, RK,
        output key_ready, key_out, key_out_valid,
        output to_sbox, to_kronecker,
        output busy, done, round_idx, cmd_err
    );
endinterface

// File: rtl/key_array_seq.sv
// Self-sequenced serial key store: one W-bit shift chain of ROWS*COLS cells
// driven by an internal load / round-update / rotate FSM.
module key_array_seq #(
    parameter int W          = 16,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int NUM_ROUNDS = 10,
    parameter int SBOX_TAP   = 13,
    parameter int KRON_TAP   = 3,
    parameter int ROT_LEN    = 4
) (
    input logic        clk,
    input logic        rst,
    key_array_if.slave bus
);
    localparam int N   = ROWS * COLS;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int RIW = $clog2(NUM_ROUNDS + 1);

    if (SBOX_TAP >= N) begin : g_bad_sbox
        $error("key_array_seq: SBOX_TAP must be below ROWS*COLS");
    end
    if (KRON_TAP >= N) begin : g_bad_kron
        $error("key_array_seq: KRON_TAP must be below ROWS*COLS");
    end
    if (ROT_LEN < 1 || ROT_LEN > N) begin : g_bad_rot
        $error("key_array_seq: ROT_LEN must be within 1..ROWS*COLS");
    end
    if ($bits(bus.key_in) != W || $bits(bus.round_idx) != RIW) begin : g_bad_if
        $error("key_array_seq: interface widths do not match parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_ROT
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [RIW-1:0]  r_ridx;
    logic            r_key_ready;
    logic            r_kov;
    logic            r_busy;
    logic            r_done;
    logic            r_cmd_err;
    logic [W-1:0]    r_cell [N];

    logic            w_shift;
    logic [W-1:0]    w_tail;
    logic            w_last_cell;
    logic            w_last_rot;

    assign w_last_cell = (r_cnt == CW'(N - 1));
    assign w_last_rot  = (r_cnt == CW'(ROT_LEN - 1));

    // ROUND and ROT shift every cycle; LOAD only on an accepted key word.
    always_comb begin
        w_shift = 1'b0;
        w_tail  = '0;
        unique case (r_state)
            S_LOAD: begin
                w_shift = bus.key_valid;
                w_tail  = bus.key_in;
            end
            S_ROUND: begin
                w_shift = 1'b1;
                w_tail  = bus.RK;
            end
            S_ROT: begin
                w_shift = 1'b1;
                w_tail  = r_cell[0];
            end
            default: begin
                w_shift = 1'b0;
                w_tail  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_cell[i] <= '0;
            end
        end else if (w_shift) begin
            for (int i = 0; i < N - 1; i++) begin
                r_cell[i] <= r_cell[i+1];
            end
            r_cell[N-1] <= w_tail;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ridx      <= '0;
            r_key_ready <= 1'b0;
            r_kov       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (bus.load_start) begin
                        r_state     <= S_LOAD;
                        r_key_ready <= 1'b1;
                        r_busy      <= 1'b1;
                    end else if (bus.round_start) begin
                        // Round budget exhausted: reject, rot_start is dropped.
                        if (r_ridx == RIW'(NUM_ROUNDS)) begin
                            r_cmd_err <= 1'b1;
                        end else begin
                            r_state <= S_ROUND;
                            r_kov   <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end else if (bus.rot_start) begin
                        r_state <= S_ROT;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.key_valid) begin
                        if (w_last_cell) begin
                            r_state     <= S_IDLE;
                            r_cnt       <= '0;
                            r_key_ready <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_ridx      <= '0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_ROUND: begin
                    if (w_last_cell) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_kov   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_ridx  <= r_ridx + RIW'(1);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_ROT: begin
                    if (w_last_rot) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.key_ready     = r_key_ready;
    assign bus.key_out_valid = r_kov;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.cmd_err       = r_cmd_err;
    assign bus.round_idx     = r_ridx;
    assign bus.key_out       = r_cell[0];
    assign bus.to_sbox       = r_cell[SBOX_TAP];
    assign bus.to_kronecker  = r_cell[KRON_TAP];
endmodule

// File: tb/tb_key_array_seq.sv
// Scoreboard bench for key_array_seq: stimulus pushes expectations from a
// queue-based key model, a negedge monitor pops and compares them.
module tb_key_array_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_array_if #(.W(16), .RIW(4)) kif ();

    key_array_seq #(
        .W(16), .ROWS(4), .COLS(4), .NUM_ROUNDS(10),
        .SBOX_TAP(13), .KRON_TAP(3), .ROT_LEN(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(kif.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit rk_mode  = 1'b0;

    typedef struct {
        logic [3:0]  ridx;
        logic [15:0] c0;
        logic [15:0] sb;
        logic [15:0] kr;
    } done_t;

    logic [15:0] q_kout [$];
    done_t       q_done [$];
    int          q_err  [$];
    logic [15:0] m      [$];
    int          m_ridx = 0;

    function automatic logic [15:0] rkf(logic [15:0] c0, logic [15:0] sb,
                                        logic [15:0] kr);
        if (rk_mode) return c0 ^ sb ^ {kr[7:0], kr[15:8]};
        return c0 ^ 16'hFFFF;
    endfunction

    assign kif.RK = rkf(kif.key_out, kif.to_sbox, kif.to_kronecker);

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_done();
        done_t d;
        d.ridx = 4'(m_ridx);
        d.c0   = m[0];
        d.sb   = m[13];
        d.kr   = m[3];
        q_done.push_back(d);
    endtask

    always @(negedge clk) begin
        if (kif.key_out_valid) begin
            if (q_kout.size() == 0) check("kout_unexpected", 1, 0);
            else check("key_out", kif.key_out, q_kout.pop_front());
        end
        if (kif.done) begin
            if (q_done.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                done_t d;
                d = q_done.pop_front();
                check("done_round_idx", kif.round_idx, d.ridx);
                check("done_c0", kif.key_out, d.c0);
                check("done_sbox", kif.to_sbox, d.sb);
                check("done_kron", kif.to_kronecker, d.kr);
            end
        end
        if (kif.cmd_err) begin
            check("cmd_err_expected", q_err.size() != 0, 1);
            if (q_err.size() != 0) void'(q_err.pop_front());
        end
    end

    task automatic pulse(input int which);
        @(posedge clk); #1;
        if (which == 0) kif.load_start = 1'b1;
        if (which == 1) kif.round_start = 1'b1;
        if (which == 2) kif.rot_start = 1'b1;
        if (which == 3) begin
            kif.load_start  = 1'b1;
            kif.round_start = 1'b1;
        end
        @(posedge clk); #1;
        kif.load_start  = 1'b0;
        kif.round_start = 1'b0;
        kif.rot_start   = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] w [16], input int sa,
                           input int sb, input bit with_round, output int cyc);
        int i;
        m.delete();
        for (int k = 0; k < 16; k++) m.push_back(w[k]);
        m_ridx = 0;
        push_done();
        pulse(with_round ? 3 : 0);
        check("key_ready_latency", kif.key_ready, 1);
        i = 0;
        cyc = 0;
        while (i < 16 && cyc < 200) begin
            kif.key_valid = (cyc != sa && cyc != sb);
            kif.key_in = kif.key_valid ? w[i] : 16'($urandom);
            @(posedge clk); #1;
            if (kif.key_valid) i++;
            cyc++;
        end
        kif.key_valid = 1'b0;
        check("load_accepts", i, 16);
        check("load_done_pulse", kif.done, 1);
        check("load_ready_drop", kif.key_ready, 0);
    endtask

    task automatic model_round();
        logic [15:0] rk;
        for (int k = 0; k < 16; k++) begin
            q_kout.push_back(m[0]);
            rk = rkf(m[0], m[13], m[3]);
            void'(m.pop_front());
            m.push_back(rk);
        end
        m_ridx++;
        push_done();
    endtask

    task automatic wait_idle(input string nm, input int len);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (kif.busy && cyc < 60);
        check(nm, cyc, len);
        check({nm, "_done"}, kif.done, 1);
    endtask

    task automatic do_round();
        if (m_ridx == 10) begin
            q_err.push_back(1);
            pulse(1);
            check("reject_cmd_err", kif.cmd_err, 1);
            check("reject_busy", kif.busy, 0);
        end else begin
            model_round();
            pulse(1);
            wait_idle("round_len", 16);
        end
    endtask

    task automatic do_rot();
        for (int k = 0; k < 4; k++) m.push_back(m.pop_front());
        push_done();
        pulse(2);
        wait_idle("rot_len", 4);
    endtask

    logic [15:0] w_seq [16];
    logic [15:0] w_rnd [16];
    int          cyc;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        kif.load_start  = 1'b0;
        kif.round_start = 1'b0;
        kif.rot_start   = 1'b0;
        kif.key_in      = '0;
        kif.key_valid   = 1'b0;
        for (int k = 0; k < 16; k++) w_seq[k] = 16'(k);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_key_ready", kif.key_ready, 0);
        check("rst_kov", kif.key_out_valid, 0);
        check("rst_busy", kif.busy, 0);
        check("rst_done", kif.done, 0);
        check("rst_cmd_err", kif.cmd_err, 0);
        check("rst_round_idx", kif.round_idx, 0);
        check("rst_key_out", kif.key_out, 0);
        for (int k = 0; k < 16; k++) m.push_back(16'h0);

        do_load(w_seq, -1, -1, 1'b0, cyc);
        check("b2b_cycles", cyc, 16);
        check("b2b_c0", kif.key_out, 16'h0000);
        check("b2b_sbox", kif.to_sbox, 16'h000D);
        check("b2b_kron", kif.to_kronecker, 16'h0003);

        do_load(w_seq, 3, 7, 1'b0, cyc);
        check("stall_cycles", cyc, 18);
        check("stall_sbox", kif.to_sbox, 16'h000D);

        rk_mode = 1'b0;
        do_round();
        check("round1_c0", kif.key_out, 16'hFFFF);
        check("round1_sbox", kif.to_sbox, 16'hFFF2);
        check("round1_idx", kif.round_idx, 1);

        do_load(w_seq, -1, -1, 1'b0, cyc);
        do_rot();
        check("rot_c0", kif.key_out, 16'h0004);
        check("rot_idx", kif.round_idx, 0);
        rk_mode = 1'b0;
        do_round();

        rk_mode = 1'b1;
        for (int k = 0; k < 16; k++) w_rnd[k] = 16'($urandom);
        do_load(w_rnd, -1, -1, 1'b0, cyc);
        for (int r = 0; r < 10; r++) do_round();
        check("ten_rounds_idx", kif.round_idx, 10);
        do_round();

        for (int k = 0; k < 16; k++) w_rnd[k] = 16'($urandom);
        do_load(w_rnd, -1, -1, 1'b1, cyc);
        check("pri_round_idx", kif.round_idx, 0);

        for (int it = 0; it < 12; it++) begin
            int op;
            op = $urandom_range(0, 2);
            rk_mode = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            if (op == 0) begin
                for (int k = 0; k < 16; k++) w_rnd[k] = 16'($urandom);
                do_load(w_rnd, $urandom_range(0, 20), $urandom_range(0, 20),
                        1'b0, cyc);
            end else if (op == 1) begin
                do_round();
            end else begin
                do_rot();
            end
        end

        model_round();
        pulse(1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q_kout.delete();
        q_done.delete();
        m.delete();
        for (int k = 0; k < 16; k++) m.push_back(16'h0);
        m_ridx = 0;
        check("mid_rst_busy", kif.busy, 0);
        check("mid_rst_idx", kif.round_idx, 0);
        check("mid_rst_kov", kif.key_out_valid, 0);
        check("mid_rst_c0", kif.key_out, 0);
        check("mid_rst_sbox", kif.to_sbox, 0);
        check("mid_rst_kron", kif.to_kronecker, 0);
        do_rot();
        for (int k = 0; k < 16; k++) w_rnd[k] = 16'($urandom);
        do_load(w_rnd, 5, -1, 1'b0, cyc);
        check("post_rst_cycles", cyc, 17);
        rk_mode = 1'b1;
        do_round();

        repeat (3) @(posedge clk);
        check("kout_queue_empty", q_kout.size(), 0);
        check("done_queue_empty", q_done.size(), 0);
        check("err_queue_empty", q_err.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
